// File: rtl/wb_pkg.sv
// wb_pkg: shared states and constants for the writeback/syscall unit.
package wb_pkg;
    typedef enum logic [1:0] {IDLE, PRINT, HALTED} wb_state_e;
    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [4:0]  REG_RA         = 5'd31;
endpackage

// File: rtl/wb_result_mux.sv
// wb_result_mux: register-file write address/data select for the W stage.
module wb_result_mux
    import wb_pkg::*;
(
    input  logic        i_jal,
    input  logic        i_memtoreg,
    input  logic [31:0] i_read_data,
    input  logic [31:0] i_alu_out,
    input  logic [4:0]  i_write_reg,
    input  logic [31:0] i_pc_plus4,
    output logic [4:0]  o_waddr,
    output logic [31:0] o_wdata
);
    always_comb begin
        o_waddr = i_jal ? REG_RA : i_write_reg;
        o_wdata = i_jal ? i_pc_plus4 : (i_memtoreg ? i_read_data : i_alu_out);
    end
endmodule

// File: rtl/wb_syscall_unit.sv
// wb_syscall_unit: W-stage result mux plus syscall/break console and halt FSM.
// Define WB_PRINT_CHAR_EN to enable the print-character syscall (code 11).
module wb_syscall_unit
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteW,
    input  logic        MemtoRegW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] ALUOutW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] PCPlus4W,
    input  logic        JalW,
    input  logic        sysW,
    input  logic        breakW,
    input  logic [31:0] regvW,
    input  logic [31:0] regaW,
    input  logic        con_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        con_valid,
    output logic [31:0] con_data,
    output logic        con_kind,
    output logic        stall,
    output logic        halted
);
    wb_state_e   r_state, w_next;
    logic [31:0] r_con_data;
    logic        r_con_kind;
    logic        w_halt_req, w_int_req, w_char_req, w_print_req, w_load;

    wb_result_mux u_mux (
        .i_jal       (JalW),
        .i_memtoreg  (MemtoRegW),
        .i_read_data (ReadDataW),
        .i_alu_out   (ALUOutW),
        .i_write_reg (WriteRegW),
        .i_pc_plus4  (PCPlus4W),
        .o_waddr     (rf_waddr),
        .o_wdata     (rf_wdata)
    );

    // break outranks any syscall present in the same cycle
    assign w_halt_req = breakW | (sysW & regvW == SYS_EXIT);
    assign w_int_req  = ~breakW & sysW & regvW == SYS_PRINT_INT;
`ifdef WB_PRINT_CHAR_EN
    assign w_char_req = ~breakW & sysW & regvW == SYS_PRINT_CHAR;
`else
    assign w_char_req = 1'b0;
`endif
    assign w_print_req = w_int_req | w_char_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        con_valid = 1'b0;
        stall     = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = w_halt_req ? HALTED : (w_print_req ? PRINT : IDLE);
                w_load = w_print_req & ~w_halt_req;
                stall  = w_load;
            end
            PRINT: begin
                con_valid = 1'b1;
                stall     = ~con_ready;
                w_next    = con_ready ? IDLE : PRINT;
            end
            default: stall = 1'b1;
        endcase
        // stall must read low while reset is held, even with a syscall still in W
        stall = stall & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_con_data <= '0;
            r_con_kind <= 1'b0;
        end else if (w_load) begin
            r_con_data <= w_char_req ? {24'b0, regaW[7:0]} : regaW;
            r_con_kind <= w_char_req;
        end
    end

    assign con_data = r_con_data;
`ifdef WB_PRINT_CHAR_EN
    assign con_kind = r_con_kind;
`else
    assign con_kind = 1'b0;
`endif
    assign halted = r_state == HALTED;
    assign rf_we  = (RegWriteW | JalW) & ~halted;
endmodule

// File: tb/tb_wb_syscall_unit.sv
// tb_wb_syscall_unit: vector table for the result mux, scoreboarded console transfers,
// and hand sequences for print backpressure, halt, break priority and mid-print reset.
module tb_wb_syscall_unit;
    logic        clk = 0, rst_n = 0;
    logic        RegWriteW = 0, MemtoRegW = 0, JalW = 0, sysW = 0, breakW = 0, con_ready = 0;
    logic [31:0] ReadDataW = 0, ALUOutW = 0, PCPlus4W = 0, regvW = 0, regaW = 0;
    logic [4:0]  WriteRegW = 0;
    logic        rf_we, con_valid, con_kind, stall, halted;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, con_data;

    int checks = 0, errors = 0, xfers = 0;
    logic [32:0] exp_q[$];

    wb_syscall_unit dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .PCPlus4W(PCPlus4W),
        .JalW(JalW), .sysW(sysW), .breakW(breakW), .regvW(regvW), .regaW(regaW),
        .con_ready(con_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .con_valid(con_valid), .con_data(con_data), .con_kind(con_kind),
        .stall(stall), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWriteW = 0; MemtoRegW = 0; JalW = 0; sysW = 0; breakW = 0;
        regvW = 0; regaW = 0; con_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        rst_n = 1;
        step();
    endtask

    always @(posedge clk) begin
        if (rst_n && con_valid && con_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("xfer_data", con_data, e[31:0]);
                chk("xfer_kind", {31'b0, con_kind}, {31'b0, e[32]});
            end
        end
    end

    typedef struct {
        logic        rw, mtr, jal;
        logic [31:0] rd, alu;
        logic [4:0]  wr;
        logic [31:0] pc4;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{1, 0, 0, 32'hDEAD, 32'h55, 5'd8, 32'h0, 1, 5'd8, 32'h55};
        vecs[1] = '{0, 0, 1, 32'h0, 32'h7, 5'd4, 32'h0040_0010, 1, 5'd31, 32'h0040_0010};
        vecs[2] = '{1, 1, 0, 32'hCAFE_F00D, 32'h1, 5'd17, 32'h0, 1, 5'd17, 32'hCAFE_F00D};
        vecs[3] = '{0, 1, 0, 32'h3, 32'h9, 5'd2, 32'h0, 0, 5'd2, 32'h3};
        vecs[4] = '{1, 1, 1, 32'h5, 32'h6, 5'd0, 32'h100, 1, 5'd31, 32'h100};

        #2;
        chk("rst_con_valid", {31'b0, con_valid}, 0);
        chk("rst_con_data", con_data, 0);
        chk("rst_con_kind", {31'b0, con_kind}, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        do_reset();

        foreach (vecs[i]) begin
            RegWriteW = vecs[i].rw; MemtoRegW = vecs[i].mtr; JalW = vecs[i].jal;
            ReadDataW = vecs[i].rd; ALUOutW = vecs[i].alu; WriteRegW = vecs[i].wr;
            PCPlus4W = vecs[i].pc4;
            #1;
            chk("vec_we", {31'b0, rf_we}, {31'b0, vecs[i].we});
            chk("vec_waddr", {27'b0, rf_waddr}, {27'b0, vecs[i].wa});
            chk("vec_wdata", rf_wdata, vecs[i].wd);
            chk("vec_stall", {31'b0, stall}, 0);
            step();
        end
        idle_inputs();
        step();

        // print int, backpressure on cycles 1-3, handshake in cycle 4
        sysW = 1; regvW = 1; regaW = 42; con_ready = 0;
        exp_q.push_back({1'b0, 32'd42});
        #1;
        chk("pi_c0_stall", {31'b0, stall}, 1);
        chk("pi_c0_valid", {31'b0, con_valid}, 0);
        for (int c = 1; c <= 4; c++) begin
            step();
            con_ready = (c == 4);
            #1;
            chk("pi_valid", {31'b0, con_valid}, 1);
            chk("pi_data", con_data, 42);
            chk("pi_kind", {31'b0, con_kind}, 0);
            chk("pi_stall", {31'b0, stall}, {31'b0, c != 4});
        end
        step();
        idle_inputs();
        #1;
        chk("pi_after_valid", {31'b0, con_valid}, 0);
        chk("pi_after_stall", {31'b0, stall}, 0);
        chk("pi_xfers", xfers, 1);

        // print char
        sysW = 1; regvW = 11; regaW = 32'h1234_5641; con_ready = 1;
`ifdef WB_PRINT_CHAR_EN
        exp_q.push_back({1'b1, 32'h41});
        #1;
        chk("pc_c0_stall", {31'b0, stall}, 1);
        step();
        chk("pc_valid", {31'b0, con_valid}, 1);
        chk("pc_data", con_data, 32'h41);
        chk("pc_kind", {31'b0, con_kind}, 1);
        step();
        idle_inputs();
        #1;
        chk("pc_xfers", xfers, 2);
`else
        #1;
        chk("pc_off_stall", {31'b0, stall}, 0);
        step();
        idle_inputs();
        #1;
        chk("pc_off_valid", {31'b0, con_valid}, 0);
        chk("pc_off_xfers", xfers, 1);
`endif

        // unknown syscall code is a no-op
        sysW = 1; regvW = 5; regaW = 7;
        #1;
        chk("nop_stall", {31'b0, stall}, 0);
        step();
        idle_inputs();
        #1;
        chk("nop_valid", {31'b0, con_valid}, 0);
        chk("nop_halted", {31'b0, halted}, 0);

        // exit
        sysW = 1; regvW = 10;
        #1;
        chk("exit_c0_halted", {31'b0, halted}, 0);
        chk("exit_c0_stall", {31'b0, stall}, 0);
        step();
        idle_inputs();
        RegWriteW = 1; WriteRegW = 5'd9;
        #1;
        chk("exit_halted", {31'b0, halted}, 1);
        chk("exit_stall", {31'b0, stall}, 1);
        chk("exit_we", {31'b0, rf_we}, 0);
        step();
        chk("exit_sticky", {31'b0, halted}, 1);
        do_reset();

        // break beats a simultaneous print request
        breakW = 1; sysW = 1; regvW = 1; regaW = 99; con_ready = 1;
        #1;
        chk("brk_c0_stall", {31'b0, stall}, 0);
        step();
        idle_inputs();
        #1;
        chk("brk_halted", {31'b0, halted}, 1);
        chk("brk_valid", {31'b0, con_valid}, 0);
        do_reset();

        // reset while a print is outstanding
        sysW = 1; regvW = 1; regaW = 77; con_ready = 0;
        step();
        chk("rp_valid", {31'b0, con_valid}, 1);
        #2;
        rst_n = 0;
        #1;
        chk("rp_rst_valid", {31'b0, con_valid}, 0);
        chk("rp_rst_stall", {31'b0, stall}, 0);
        idle_inputs();
        step();
        rst_n = 1;
        step();
        chk("rp_idle_valid", {31'b0, con_valid}, 0);
        chk("rp_idle_stall", {31'b0, stall}, 0);
        chk("rp_idle_halted", {31'b0, halted}, 0);
        chk("rp_xfers", xfers, exp_q.size() == 0 ? xfers : -1);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
